// File: rtl/mulseq_pkg.sv
// Shared widths, state/step encodings and partial-product placement for mulseq4848.
package mulseq_pkg;

    localparam int unsigned HWID  = 24;
    localparam int unsigned OPWID = 2 * HWID;
    localparam int unsigned RSWID = 2 * OPWID;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Step index bit 1 selects the high half of ra, bit 0 the high half of rb
    localparam logic [1:0] STEP_LL = 2'd0;
    localparam logic [1:0] STEP_LH = 2'd1;
    localparam logic [1:0] STEP_HL = 2'd2;
    localparam logic [1:0] STEP_HH = 2'd3;

    localparam int unsigned SHIFT_LL = 0;
    localparam int unsigned SHIFT_LH = HWID;
    localparam int unsigned SHIFT_HL = HWID;
    localparam int unsigned SHIFT_HH = OPWID;

    // Zero-extend a partial product and move it to its weight for the given step
    function automatic logic [RSWID-1:0] place_pp(input logic [OPWID-1:0] pp,
                                                  input logic [1:0]       step);
        logic [RSWID-1:0] ext;
        ext = RSWID'(pp);
        case (step)
            STEP_LL: place_pp = ext << SHIFT_LL;
            STEP_LH: place_pp = ext << SHIFT_LH;
            STEP_HL: place_pp = ext << SHIFT_HL;
            default: place_pp = ext << SHIFT_HH;
        endcase
    endfunction

endpackage

// File: rtl/i2424vedic.sv
// 24x24 -> 48 unsigned combinational multiplier, vertical-and-crosswise on 12-bit halves.
module i2424vedic (
    input  logic [23:0] i_a,
    input  logic [23:0] i_b,
    output logic [47:0] o_p
);

    logic [23:0] w_ll;
    logic [23:0] w_lh;
    logic [23:0] w_hl;
    logic [23:0] w_hh;
    logic [24:0] w_cross;

    assign w_ll = 24'(i_a[11:0])  * 24'(i_b[11:0]);
    assign w_lh = 24'(i_a[11:0])  * 24'(i_b[23:12]);
    assign w_hl = 24'(i_a[23:12]) * 24'(i_b[11:0]);
    assign w_hh = 24'(i_a[23:12]) * 24'(i_b[23:12]);

    // Crosswise terms share weight 2^12 and are summed before placement
    assign w_cross = 25'(w_lh) + 25'(w_hl);
    assign o_p     = {w_hh, w_ll} + (48'(w_cross) << 12);

endmodule

// File: rtl/mulseq4848.sv
// 48x48 unsigned multiplier sequencing one shared 24x24 multiplier over four steps.
// Define MULSEQ_PIPE_EN to register the multiplier output (adds one MUL cycle).
module mulseq4848
    import mulseq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [OPWID-1:0] in_a,
    input  logic [OPWID-1:0] in_b,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [RSWID-1:0] out_rslt,
    output logic             busy
);

`ifdef MULSEQ_PIPE_EN
    localparam logic [2:0] LAST_CYC = 3'd4;
`else
    localparam logic [2:0] LAST_CYC = 3'd3;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_cyc;
    logic [2:0]       w_cyc_nxt;
    logic [OPWID-1:0] r_ra;
    logic [OPWID-1:0] r_rb;
    logic [OPWID-1:0] w_ra_nxt;
    logic [OPWID-1:0] w_rb_nxt;
    logic [RSWID-1:0] r_acc;
    logic [RSWID-1:0] w_acc_nxt;
    logic             r_in_rdy;
    logic             r_out_vld;
    logic             r_busy;
    logic             w_in_rdy_nxt;
    logic             w_out_vld_nxt;
    logic             w_busy_nxt;

    logic [1:0]       w_issue_step;
    logic [HWID-1:0]  w_mul_a;
    logic [HWID-1:0]  w_mul_b;
    logic [OPWID-1:0] w_pp;
    logic             w_add_en;
    logic [OPWID-1:0] w_add_pp;
    logic [1:0]       w_add_step;

    // Operand mux into the shared multiplier
    assign w_issue_step = r_cyc[1:0];
    assign w_mul_a      = w_issue_step[1] ? r_ra[OPWID-1:HWID] : r_ra[HWID-1:0];
    assign w_mul_b      = w_issue_step[0] ? r_rb[OPWID-1:HWID] : r_rb[HWID-1:0];

    i2424vedic u_mul (
        .i_a (w_mul_a),
        .i_b (w_mul_b),
        .o_p (w_pp)
    );

`ifdef MULSEQ_PIPE_EN
    logic [OPWID-1:0] r_pp;
    logic [1:0]       r_pp_step;
    logic             r_pp_vld;

    // Product register; accumulation trails issue by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pp      <= '0;
            r_pp_step <= STEP_LL;
            r_pp_vld  <= 1'b0;
        end else begin
            r_pp      <= w_pp;
            r_pp_step <= w_issue_step;
            r_pp_vld  <= (r_state == ST_MUL) && (r_cyc != LAST_CYC);
        end
    end

    assign w_add_en   = r_pp_vld;
    assign w_add_pp   = r_pp;
    assign w_add_step = r_pp_step;
`else
    assign w_add_en   = (r_state == ST_MUL);
    assign w_add_pp   = w_pp;
    assign w_add_step = w_issue_step;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cyc     <= 3'd0;
            r_ra      <= '0;
            r_rb      <= '0;
            r_acc     <= '0;
            r_in_rdy  <= 1'b1;
            r_out_vld <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cyc     <= w_cyc_nxt;
            r_ra      <= w_ra_nxt;
            r_rb      <= w_rb_nxt;
            r_acc     <= w_acc_nxt;
            r_in_rdy  <= w_in_rdy_nxt;
            r_out_vld <= w_out_vld_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_ra_nxt    = r_ra;
        w_rb_nxt    = r_rb;
        w_acc_nxt   = r_acc;

        case (r_state)
            ST_IDLE: begin
                if (in_vld && r_in_rdy) begin
                    w_ra_nxt    = in_a;
                    w_rb_nxt    = in_b;
                    w_acc_nxt   = '0;
                    w_cyc_nxt   = 3'd0;
                    w_state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                if (w_add_en) begin
                    w_acc_nxt = r_acc + place_pp(w_add_pp, w_add_step);
                end
                w_cyc_nxt = r_cyc + 3'd1;
                if (r_cyc == LAST_CYC) begin
                    w_cyc_nxt   = 3'd0;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Handshake flags are pure functions of the next state, so they register cleanly
        w_in_rdy_nxt  = (w_state_nxt == ST_IDLE);
        w_out_vld_nxt = (w_state_nxt == ST_DONE);
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
    end

    assign in_rdy   = r_in_rdy;
    assign out_vld  = r_out_vld;
    assign busy     = r_busy;
    assign out_rslt = r_acc;

endmodule
